// File: rtl/rat_commit_if.sv
// Bundle between the commit controller, the ROB head/walk ports and the RAT commit/release/restore ports.
// master = commit controller side, slave = ROB/RAT side.
interface rat_commit_if #(
    parameter int PHY_REG_NUM      = 64,
    parameter int COMMIT_WIDTH     = 4,
    parameter int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM)
);
    localparam int CNT_W = $clog2(COMMIT_WIDTH) + 1;

    logic [COMMIT_WIDTH-1:0]                       rob_commit_valid;
    logic [COMMIT_WIDTH-1:0]                       rob_commit_has_dest;
    logic [COMMIT_WIDTH-1:0]                       rob_commit_exception;
    logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] rob_commit_new_phy_id;
    logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] rob_commit_old_phy_id;
    logic [CNT_W-1:0]                              commit_rob_pop_num;

    logic                        rob_walk_start;
    logic                        rob_walk_valid;
    logic                        rob_walk_last;
    logic                        rob_walk_has_dest;
    logic [PHY_REG_ID_WIDTH-1:0] rob_walk_new_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] rob_walk_old_phy_id;
    logic                        commit_rob_walk_ready;

    logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] commit_rat_commit_phy_id;
    logic [COMMIT_WIDTH-1:0]                       commit_rat_commit_valid;
    logic                                          commit_rat_commit_map;
    logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] commit_rat_release_phy_id;
    logic [COMMIT_WIDTH-1:0]                       commit_rat_release_valid;
    logic                                          commit_rat_release_map;

    logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_phy_id;
    logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_phy_id;
    logic                        commit_rat_restore_map;

    logic [PHY_REG_NUM-1:0] commit_rat_map_table_valid;
    logic [PHY_REG_NUM-1:0] commit_rat_map_table_visible;
    logic                   commit_rat_map_table_restore;
    logic                   commit_flush;

    modport master (
        input  rob_commit_valid, rob_commit_has_dest, rob_commit_exception,
               rob_commit_new_phy_id, rob_commit_old_phy_id,
               rob_walk_start, rob_walk_valid, rob_walk_last, rob_walk_has_dest,
               rob_walk_new_phy_id, rob_walk_old_phy_id,
        output commit_rob_pop_num, commit_rob_walk_ready,
               commit_rat_commit_phy_id, commit_rat_commit_valid, commit_rat_commit_map,
               commit_rat_release_phy_id, commit_rat_release_valid, commit_rat_release_map,
               commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id, commit_rat_restore_map,
               commit_rat_map_table_valid, commit_rat_map_table_visible,
               commit_rat_map_table_restore, commit_flush
    );

    modport slave (
        output rob_commit_valid, rob_commit_has_dest, rob_commit_exception,
               rob_commit_new_phy_id, rob_commit_old_phy_id,
               rob_walk_start, rob_walk_valid, rob_walk_last, rob_walk_has_dest,
               rob_walk_new_phy_id, rob_walk_old_phy_id,
        input  commit_rob_pop_num, commit_rob_walk_ready,
               commit_rat_commit_phy_id, commit_rat_commit_valid, commit_rat_commit_map,
               commit_rat_release_phy_id, commit_rat_release_valid, commit_rat_release_map,
               commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id, commit_rat_restore_map,
               commit_rat_map_table_valid, commit_rat_map_table_visible,
               commit_rat_map_table_restore, commit_flush
    );
endinterface

// File: rtl/rat_commit_ctrl.sv
// Commit-side RAT driver: retires ROB head entries, tracks architectural valid/visible vectors,
// issues a bulk restore on a head exception and replays mispredict walks as single restores.
module rat_commit_ctrl #(
    parameter int PHY_REG_NUM      = 64,
    parameter int ARCH_REG_NUM     = 32,
    parameter int COMMIT_WIDTH     = 4,
    parameter int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    rat_commit_if.master  bus
);
    localparam int CNT_W = $clog2(COMMIT_WIDTH) + 1;
    localparam logic [PHY_REG_NUM-1:0] ARCH_INIT =
        {{(PHY_REG_NUM-ARCH_REG_NUM){1'b0}}, {(ARCH_REG_NUM-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, FLUSH, WALK} state_t;

    state_t                                        state_q;
    logic [PHY_REG_NUM-1:0]                        valid_q, valid_d;
    logic [PHY_REG_NUM-1:0]                        visible_q, visible_d;
    logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] commit_id_q, release_id_q;
    logic [COMMIT_WIDTH-1:0]                       commit_vld_q, release_vld_q;
    logic [COMMIT_WIDTH-1:0]                       commit_vld_d, release_vld_d;
    logic                                          commit_map_q, release_map_q;
    logic [PHY_REG_ID_WIDTH-1:0]                   restore_new_q, restore_old_q;
    logic                                          restore_map_q;
    logic                                          table_restore_q, flush_q;

    logic [CNT_W-1:0] commit_n;
    logic             run;
    logic             exc_head, walk_accept, do_commit;

    // Retire only the unbroken run of clean entries starting at the oldest slot.
    always_comb begin
        commit_n = '0;
        run      = 1'b1;
        for (int w = 0; w < COMMIT_WIDTH; w++) begin
            if (run && bus.rob_commit_valid[w] && !bus.rob_commit_exception[w]) begin
                commit_n = CNT_W'(w + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign exc_head    = (state_q == IDLE) && bus.rob_commit_valid[0] && bus.rob_commit_exception[0];
    assign walk_accept = (state_q == IDLE) && !exc_head && bus.rob_walk_start;
    assign do_commit   = (state_q == IDLE) && !exc_head && !walk_accept;

    // Slots are applied oldest first so a younger clear wins over an older set of the same id.
    always_comb begin
        valid_d       = valid_q;
        visible_d     = visible_q;
        commit_vld_d  = '0;
        release_vld_d = '0;
        for (int w = 0; w < COMMIT_WIDTH; w++) begin
            if (do_commit && (w < int'(commit_n)) && bus.rob_commit_has_dest[w]) begin
                commit_vld_d[w]  = (bus.rob_commit_new_phy_id[w] != '0);
                release_vld_d[w] = (bus.rob_commit_old_phy_id[w] != '0);
                valid_d[bus.rob_commit_new_phy_id[w]]   = 1'b1;
                visible_d[bus.rob_commit_new_phy_id[w]] = 1'b1;
                valid_d[bus.rob_commit_old_phy_id[w]]   = 1'b0;
                visible_d[bus.rob_commit_old_phy_id[w]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            valid_q         <= ARCH_INIT;
            visible_q       <= ARCH_INIT;
            commit_id_q     <= '0;
            release_id_q    <= '0;
            commit_vld_q    <= '0;
            release_vld_q   <= '0;
            commit_map_q    <= 1'b0;
            release_map_q   <= 1'b0;
            restore_new_q   <= '0;
            restore_old_q   <= '0;
            restore_map_q   <= 1'b0;
            table_restore_q <= 1'b0;
            flush_q         <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            visible_q       <= visible_d;
            commit_vld_q    <= commit_vld_d;
            release_vld_q   <= release_vld_d;
            commit_map_q    <= |commit_vld_d;
            release_map_q   <= |release_vld_d;
            for (int w = 0; w < COMMIT_WIDTH; w++) begin
                commit_id_q[w]  <= commit_vld_d[w]  ? bus.rob_commit_new_phy_id[w] : '0;
                release_id_q[w] <= release_vld_d[w] ? bus.rob_commit_old_phy_id[w] : '0;
            end
            restore_new_q   <= '0;
            restore_old_q   <= '0;
            restore_map_q   <= 1'b0;
            table_restore_q <= 1'b0;
            flush_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exc_head) begin
                        state_q <= FLUSH;
                    end else if (walk_accept) begin
                        state_q <= WALK;
                    end
                end
                FLUSH: begin
                    table_restore_q <= 1'b1;
                    flush_q         <= 1'b1;
                    state_q         <= IDLE;
                end
                WALK: begin
                    if (bus.rob_walk_valid) begin
                        restore_map_q <= bus.rob_walk_has_dest;
                        if (bus.rob_walk_has_dest) begin
                            restore_new_q <= bus.rob_walk_new_phy_id;
                            restore_old_q <= bus.rob_walk_old_phy_id;
                        end
                        if (bus.rob_walk_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.commit_rob_pop_num            = do_commit ? commit_n : '0;
    assign bus.commit_rob_walk_ready         = (state_q == WALK);
    assign bus.commit_rat_commit_phy_id      = commit_id_q;
    assign bus.commit_rat_commit_valid       = commit_vld_q;
    assign bus.commit_rat_commit_map         = commit_map_q;
    assign bus.commit_rat_release_phy_id     = release_id_q;
    assign bus.commit_rat_release_valid      = release_vld_q;
    assign bus.commit_rat_release_map        = release_map_q;
    assign bus.commit_rat_restore_new_phy_id = restore_new_q;
    assign bus.commit_rat_restore_old_phy_id = restore_old_q;
    assign bus.commit_rat_restore_map        = restore_map_q;
    assign bus.commit_rat_map_table_valid    = valid_q;
    assign bus.commit_rat_map_table_visible  = visible_q;
    assign bus.commit_rat_map_table_restore  = table_restore_q;
    assign bus.commit_flush                  = flush_q;
endmodule
